// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared load/store size codes, load FSM encodings and alignment helper
package risc_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // Reserved size code 2'b11 is reported as misaligned.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic ok;
        case (size)
            LD_BYTE: ok = 1'b1;
            LD_HALF: ok = ~addr_lo[0];
            LD_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian byte/half/word extraction with sign or zero extension
module load_align
    import risc_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it to 32 bits; word loads pass through.
    always_comb begin
        byte_v = 8'h00;
        case (addr_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LD_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
            LD_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - data memory load unit with configurable RAM read latency
module load_unit
    import risc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    output logic              ld_busy,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              ld_misalign,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       data_q, data_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       align_data;

    // High address bits fall outside the RAM and wrap by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ld_addr[31:ADDR_W+2];

    load_align u_align (
        .rdata_i  (mem_rdata),
        .addr_i   (addr_lo_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (align_data)
    );

    // Next-state logic: accept in IDLE, pulse mem_en in ISSUE, count down in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        signed_d   = signed_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        data_d     = data_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_req) begin
                    addr_lo_d = ld_addr[1:0];
                    size_d    = ld_size;
                    signed_d  = ld_signed;
                    if (is_aligned(ld_addr[1:0], ld_size)) begin
                        mem_addr_d = ld_addr[ADDR_W+1:2];
                        mem_en_d   = 1'b1;
                        state_d    = ST_ISSUE;
                    end else begin
                        valid_d    = 1'b1;
                        misalign_d = 1'b1;
                        data_d     = '0;
                        state_d    = ST_ERR;
                    end
                end
            end
            ST_ISSUE: begin
                mem_en_d = 1'b0;
                cnt_d    = LAT_M1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    data_d  = align_data;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE, ST_ERR: begin
                valid_d    = 1'b0;
                misalign_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            addr_lo_q  <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            data_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            data_q     <= data_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign ld_busy     = (state_q != ST_IDLE);
    assign ld_valid    = valid_q;
    assign ld_misalign = misalign_q;
    assign ld_data     = data_q;
    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit at read latency 1 and 3
module tb_load_unit;

    logic        clk;
    logic        rst;

    logic        req1, sgn1, busy1, valid1, mis1, en1;
    logic [31:0] addr1, data1, rdata1;
    logic [1:0]  size1;
    logic [9:0]  maddr1;

    logic        req3, sgn3, busy3, valid3, mis3, en3;
    logic [31:0] addr3, data3, rdata3;
    logic [1:0]  size3;
    logic [9:0]  maddr3;

    logic [31:0] ram [0:1023];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];
    int          en_cnt1, en_cnt3;
    int          n_checks, n_pass, n_fail;

    load_unit #(.ADDR_W(10), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .ld_req(req1), .ld_addr(addr1), .ld_size(size1),
        .ld_signed(sgn1), .ld_busy(busy1), .ld_valid(valid1), .ld_data(data1),
        .ld_misalign(mis1), .mem_en(en1), .mem_addr(maddr1), .mem_rdata(rdata1)
    );

    load_unit #(.ADDR_W(10), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .ld_req(req3), .ld_addr(addr3), .ld_size(size3),
        .ld_signed(sgn3), .ld_busy(busy3), .ld_valid(valid3), .ld_data(data3),
        .ld_misalign(mis3), .mem_en(en3), .mem_addr(maddr3), .mem_rdata(rdata3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: data appears MEM_LAT cycles after the enable; garbage otherwise.
    always @(posedge clk) begin
        pipe1    <= en1 ? ram[maddr1] : 32'h5A5A_A5A5;
        pipe3[0] <= en3 ? ram[maddr3] : 32'h5A5A_A5A5;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (en1) en_cnt1 <= en_cnt1 + 1;
        if (en3) en_cnt3 <= en_cnt3 + 1;
    end
    assign rdata1 = pipe1;
    assign rdata3 = pipe3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One load on the latency-1 unit, checked cycle by cycle from acceptance.
    task automatic load1(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] exp_d, input logic exp_mis);
        int en_before;
        @(negedge clk);
        req1 = 1'b1; addr1 = a; size1 = sz; sgn1 = sg;
        en_before = en_cnt1;
        @(negedge clk);
        req1 = 1'b0;
        chk({tag, "/busy"}, 32'(busy1), 32'd1);
        if (exp_mis) begin
            chk({tag, "/err_valid"}, 32'(valid1), 32'd1);
            chk({tag, "/err_flag"}, 32'(mis1), 32'd1);
            chk({tag, "/err_data"}, data1, 32'd0);
            chk({tag, "/no_mem_en"}, 32'(en1), 32'd0);
        end else begin
            chk({tag, "/mem_en"}, 32'(en1), 32'd1);
            chk({tag, "/mem_addr"}, 32'(maddr1), 32'(a[11:2]));
            @(negedge clk);
            chk({tag, "/early_valid"}, 32'(valid1), 32'd0);
            chk({tag, "/en_once"}, 32'(en1), 32'd0);
            @(negedge clk);
            chk({tag, "/valid"}, 32'(valid1), 32'd1);
            chk({tag, "/data"}, data1, exp_d);
            chk({tag, "/mis"}, 32'(mis1), 32'd0);
        end
        @(negedge clk);
        chk({tag, "/valid_drop"}, 32'(valid1), 32'd0);
        chk({tag, "/idle"}, 32'(busy1), 32'd0);
        chk({tag, "/en_count"}, 32'(en_cnt1 - en_before), exp_mis ? 32'd0 : 32'd1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        en_cnt1 = 0; en_cnt3 = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[0] = 32'h80FF_7F01;
        ram[2] = 32'h8001_7FFE;
        ram[5] = 32'hDEAD_BEEF;
        req1 = 0; addr1 = 0; size1 = 0; sgn1 = 0;
        req3 = 0; addr3 = 0; size3 = 0; sgn3 = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        chk("rst/busy", 32'(busy1), 32'd0);
        chk("rst/valid", 32'(valid1), 32'd0);
        chk("rst/mem_en", 32'(en1), 32'd0);
        chk("rst/data", data1, 32'd0);
        chk("rst/mem_addr", 32'(maddr3), 32'd0);
        chk("rst/mis", 32'(mis3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        load1("word",      32'h14,   2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
        load1("word_sgn",  32'h14,   2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0);
        load1("word_wrap", 32'h1014, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);
        load1("b0s",       32'h0,    2'b00, 1'b1, 32'h0000_0001, 1'b0);
        load1("b1s",       32'h1,    2'b00, 1'b1, 32'h0000_007F, 1'b0);
        load1("b2s",       32'h2,    2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0);
        load1("b3s",       32'h3,    2'b00, 1'b1, 32'hFFFF_FF80, 1'b0);
        load1("b3u",       32'h3,    2'b00, 1'b0, 32'h0000_0080, 1'b0);
        load1("h8s",       32'h8,    2'b01, 1'b1, 32'h0000_7FFE, 1'b0);
        load1("hAs",       32'hA,    2'b01, 1'b1, 32'hFFFF_8001, 1'b0);
        load1("hAu",       32'hA,    2'b01, 1'b0, 32'h0000_8001, 1'b0);
        load1("mis_half",  32'h3,    2'b01, 1'b0, 32'h0,         1'b1);
        load1("mis_word",  32'h2,    2'b10, 1'b0, 32'h0,         1'b1);
        load1("mis_size",  32'h0,    2'b11, 1'b0, 32'h0,         1'b1);
        load1("after_err", 32'h8,    2'b10, 1'b0, 32'h8001_7FFE, 1'b0);

        // Two requests held back-to-back on the latency-3 unit.
        @(negedge clk);
        req3 = 1'b1; addr3 = 32'h14; size3 = 2'b10; sgn3 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr3 = 32'hA; size3 = 2'b01; sgn3 = 1'b1;
            end
            if (k == 7) req3 = 1'b0;
            chk($sformatf("b2b/valid@%0d", k), 32'(valid3), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            chk($sformatf("b2b/mem_en@%0d", k), 32'(en3), (k == 1 || k == 7) ? 32'd1 : 32'd0);
            if (k == 1) chk("b2b/addr1", 32'(maddr3), 32'd5);
            if (k == 7) chk("b2b/addr2", 32'(maddr3), 32'd2);
            if (k == 5) chk("b2b/data1", data3, 32'hDEAD_BEEF);
            if (k == 11) chk("b2b/data2", data3, 32'hFFFF_8001);
            if (k == 6) chk("b2b/idle_gap", 32'(busy3), 32'd0);
        end
        chk("b2b/en_count", 32'(en_cnt3), 32'd2);

        // Reset during WAIT abandons the read.
        @(negedge clk);
        req3 = 1'b1; addr3 = 32'h8; size3 = 2'b10; sgn3 = 1'b0;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        chk("midrst/in_wait", 32'(busy3), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst/busy", 32'(busy3), 32'd0);
        chk("midrst/data", data3, 32'd0);
        chk("midrst/valid", 32'(valid3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("midrst/no_valid@%0d", k), 32'(valid3), 32'd0);
        end
        @(negedge clk);
        req3 = 1'b1; addr3 = 32'h2; size3 = 2'b01; sgn3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req3 = 1'b0;
            chk($sformatf("post/valid@%0d", k), 32'(valid3), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) chk("post/data", data3, 32'h0000_80FF);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Reader side of the RISC data memory. It accepts a load request from the execute/memory stage and drives a word-wide synchronous data RAM with configurable read latency. It extracts the addressed byte, halfword or word (little-endian), sign- or zero-extends it, and returns a single-cycle result pulse. Misaligned accesses are flagged and never issued to memory.

Parameters:
ADDR_W, 10, word-address width of data RAM (byte address bits [ADDR_W+1:2] used)
MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata (legal 1..7)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
ld_req  input  1  load request; sampled only when ld_busy=0
ld_addr  input  32  byte address
ld_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
ld_signed  input  1  1 = sign-extend, 0 = zero-extend (ignored for word)
ld_busy  output  1  high while a request is in flight
ld_valid  output  1  one-cycle result strobe
ld_data  output  32  loaded, extended data; qualified by ld_valid
ld_misalign  output  1  error flag, qualified by ld_valid
mem_en  output  1  one-cycle RAM read enable
mem_addr  output  ADDR_W  RAM word address
mem_rdata  input  32  RAM read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. ld_busy, ld_valid, ld_misalign, mem_en = 0; ld_data, mem_addr = 0; latency counter = 0. An in-flight read is abandoned and late mem_rdata is ignored.
- States: IDLE, ISSUE, WAIT, DONE, ERR. ld_busy = (state != IDLE).
- IDLE: if ld_req=1, register addr[1:0], size and signed.
  - Aligned (byte; half with addr[0]=0; word with addr[1:0]=00): mem_addr <= ld_addr[ADDR_W+1:2], mem_en <= 1, go to ISSUE.
  - Otherwise: go to ERR; mem_en stays 0.
- ISSUE: mem_en high for exactly this cycle. Counter <= MEM_LAT-1, go to WAIT.
- WAIT: if counter=0, capture mem_rdata, extract and extend, ld_data <= result, ld_valid <= 1, go to DONE. Otherwise decrement the counter.
- DONE: ld_valid=1 and ld_misalign=0 for one cycle, then IDLE. ld_data holds its value until the next result.
- ERR: ld_valid=1, ld_misalign=1 and ld_data=0 for one cycle, then IDLE.
- Latency: request accepted at edge N. mem_en is high in cycle N+1. ld_valid is high in cycle N+2+MEM_LAT (3 cycles after acceptance for MEM_LAT=1). A misaligned request gives ld_valid in cycle N+1.
- Back-to-back: ld_req is ignored while ld_busy=1, including the DONE/ERR cycle. The next request is accepted at the earliest in the cycle after ld_valid. There is no queueing, and the requester must hold ld_req until it sees ld_busy.
- Extraction (little-endian):
  - byte = rdata[8*a+7 : 8*a], where a = addr[1:0].
  - half = rdata[15:0] when addr[1]=0, rdata[31:16] when addr[1]=1.
  - Sign extension replicates the MSB of the extracted field; zero extension fills with 0.
- Address bits [31:ADDR_W+2] are ignored, so addresses wrap modulo the RAM size.
- Reset asserted mid-WAIT: return to IDLE immediately and produce no ld_valid for the abandoned request.

Decomposition:
- Shared package risc_pkg holds:
  - size codes LD_BYTE=2'b00, LD_HALF=2'b01, LD_WORD=2'b10
  - state encodings for IDLE/ISSUE/WAIT/DONE/ERR
- One natural sub-module, load_align: purely combinational, inputs rdata, addr[1:0], size, signed; output 32-bit extended data. It is instantiated in load_unit and reused by the future store unit's read-modify-write path.

Test Plan:
1. Reset then word load: RAM word 5 = 0xDEADBEEF, MEM_LAT=1; ld_req addr=0x14 size=10 -> mem_en=1 one cycle with mem_addr=5; ld_valid 3 cycles after accept with ld_data=0xDEADBEEF, ld_misalign=0.
2. Byte sign/zero extend: word 0 = 0x80FF7F01; byte loads at addr 0..3 signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; addr 3 unsigned -> 0x00000080.
3. Halfword: word 2 = 0x8001_7FFE; addr 0x8 signed -> 0x00007FFE; addr 0xA signed -> 0xFFFF8001; addr 0xA unsigned -> 0x00008001.
4. Misalign: half at 0x3 and word at 0x2 -> mem_en never high; ld_valid next cycle with ld_misalign=1, ld_data=0. ld_size=11 -> same error response.
5. Latency and back-to-back with MEM_LAT=3: two requests held continuously -> ld_valid 5 cycles after the first accept; second accepted the cycle after ld_valid; mem_en pulses exactly once per request.
6. Reset mid-operation: assert rst during WAIT with MEM_LAT=3 -> outputs 0 asynchronously, no ld_valid afterwards; a new request after release completes normally.
